// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and GF(2^8) helper.
// Imported by every file of the iterative AES-128 cipher.
// Pure declarations only; no hardware is instantiated here.
package aes_pkg;

  localparam int NR       = 10;    // rounds for AES-128
  localparam int NB       = 4;     // columns in the state
  localparam int BLOCK_W  = 128;   // block width in bits
  localparam int EXPKEY_W = 1408;  // (NR+1) round keys of BLOCK_W bits

  // Controller encoding
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box, one byte.
// Purely combinational table lookup.
// Sixteen copies perform SubBytes on the whole state.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[data];

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock, 16 S-boxes shared by all rounds.
// Latency 10 cycles from the start edge to the done pulse; one block per 11 edges.
// start is ignored while busy; a start in the done cycle is accepted back-to-back.
module aes_cipher_iter
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [0:BLOCK_W-1]  plaintext,
  input  logic [0:EXPKEY_W-1] w,
  output logic                busy,
  output logic                done,
  output logic [0:BLOCK_W-1]  ciphertext
);

  // State byte (row r, column c) lives at byte index r + 4*c; row r rotates left by r
  function automatic logic [0:BLOCK_W-1] shift_rows(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%NB)) +: 8];
      end
    end
    return o;
  endfunction

  // Each column multiplied by the circulant {02,03,01,01} matrix
  function automatic logic [0:BLOCK_W-1] mix_columns(input logic [0:BLOCK_W-1] s);
    logic [0:BLOCK_W-1] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic               fsm_state;
  logic [3:0]         round;
  logic [0:BLOCK_W-1] blk;
  logic [0:BLOCK_W-1] sub_bytes;
  logic [0:BLOCK_W-1] shifted;
  logic [0:BLOCK_W-1] mixed;
  logic [0:BLOCK_W-1] round_key;
  logic [0:BLOCK_W-1] round_out;
  logic               last_round;

  // w is held stable by the key-expansion stage for the whole operation, so it is read live
  assign round_key  = w[{round, 7'b0} +: BLOCK_W];
  assign last_round = (round == 4'(NR));

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data (blk[8*i +: 8]),
      .sub  (sub_bytes[8*i +: 8])
    );
  end

  // One full cipher round on the held state; the final round skips MixColumns
  always_comb begin
    shifted   = shift_rows(sub_bytes);
    mixed     = last_round ? shifted : mix_columns(shifted);
    round_out = mixed ^ round_key;
  end

  // Controller: load on start, iterate rounds, publish result and pulse done on the last round
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state  <= IDLE;
      round      <= 4'd0;
      blk        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      case (fsm_state)
        IDLE: begin
          round <= 4'd0;
          if (start) begin
            blk       <= plaintext ^ w[0:BLOCK_W-1];
            round     <= 4'd1;
            busy      <= 1'b1;
            fsm_state <= RUN;
          end
        end
        RUN: begin
          blk <= round_out;
          if (last_round) begin
            ciphertext <= round_out;
            done       <= 1'b1;
            busy       <= 1'b0;
            round      <= 4'd0;
            fsm_state  <= IDLE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          round     <= 4'd0;
          busy      <= 1'b0;
          fsm_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter with a ciphertext scoreboard.
// Key schedule and S-box are rebuilt here from GF(2^8) arithmetic.
// Covers reset, FIPS-197 vectors, back-to-back, ignored starts and mid-run reset.
module tb_aes_cipher_iter;

  localparam logic [0:127] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [0:127]  plaintext;
  logic [0:1407] w;
  logic          busy;
  logic          done;
  logic [0:127]  ciphertext;

  always #5 clk = ~clk;

  aes_cipher_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .w          (w),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int dones    = 0;
  int hold_err = 0;
  logic         rst_at_edge = 1'b0;
  logic         prev_done   = 1'b0;
  logic [0:127] last_ct     = '0;
  logic [127:0] exp_q[$];
  int           start_q[$];
  logic [7:0]   tb_sb[256];
  logic [0:1407] w1, w2;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] gf_x(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = gf_x(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0]   wd[44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wd[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sb[t[31:24]], tb_sb[t[23:16]], tb_sb[t[15:8]], tb_sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_x(rc);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[32*i +: 32] = wd[i];
    return o;
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Output monitor: scoreboard pop on done, pulse width, ciphertext hold
  always @(negedge clk) begin
    if (rst_at_edge || done) last_ct = ciphertext;
    else if (ciphertext !== last_ct) hold_err++;
    if (done && prev_done) check("done_pulse_width", 1, 0);
    if (done) begin
      dones++;
      if (exp_q.size() == 0) check("spurious_done", 1, 0);
      else begin
        check("sb_ct", ciphertext, exp_q.pop_front());
        check("sb_latency", cyc - start_q.pop_front(), 10);
        check("busy_at_done", busy, 0);
      end
    end
    prev_done = done;
  end

  // Called at a negedge; returns at the next negedge with start dropped
  task automatic drive_start(input logic [0:127] pt, input logic [0:1407] wk,
                             input logic [0:127] exp, input bit accept);
    plaintext = pt;
    w         = wk;
    start     = 1'b1;
    if (accept) begin
      exp_q.push_back(exp);
      start_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int at);
    bit seen = 0;
    at = -1;
    for (int i = 0; i < max && !seen; i++) begin
      if (done) begin
        seen = 1;
        at   = cyc;
      end else @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, t1, t2, d0;
    build_sbox();
    w1 = expand(KEY1);
    w2 = expand(KEY2);

    // Reset held two cycles with start asserted
    rst = 1'b1; start = 1'b1; plaintext = PT1; w = w1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ct", ciphertext, 0);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_no_done", dones, 0);

    // FIPS-197 Appendix B, then Appendix C.1 back-to-back in the done cycle
    drive_start(PT1, w1, CT1, 1);
    s = cyc;
    check("busy_running", busy, 1);
    wait_done(15, t1);
    check("fips_b_latency", t1 - s, 10);
    check("fips_b_ct", ciphertext, CT1);
    drive_start(PT2, w2, CT2, 1);
    repeat (4) @(negedge clk);
    check("ct_held_b2b", ciphertext, CT1);
    wait_done(15, t2);
    check("b2b_gap", t2 - t1, 11);
    check("fips_c1_ct", ciphertext, CT2);
    @(negedge clk);

    // Starts while busy at rounds 3 and 9 must be ignored
    d0 = dones;
    drive_start(PT1, w1, CT1, 1);
    repeat (2) @(negedge clk);
    drive_start(PT2, w1, CT2, 0);
    repeat (5) @(negedge clk);
    drive_start(PT2, w1, CT2, 0);
    wait_done(15, t1);
    check("busy_start_ct", ciphertext, CT1);
    repeat (14) @(negedge clk);
    check("busy_start_one_done", dones - d0, 1);
    check("busy_start_idle", busy, 0);

    // Reset at round 5 aborts; start accepted in the first cycle after reset
    d0 = dones;
    drive_start(PT2, w2, CT2, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    start_q.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ct", ciphertext, 0);
    rst = 1'b0;
    drive_start(PT1, w1, CT1, 1);
    s = cyc;
    wait_done(15, t1);
    check("post_rst_latency", t1 - s, 10);
    check("post_rst_ct", ciphertext, CT1);
    repeat (14) @(negedge clk);
    check("abort_no_done", dones - d0, 1);

    check("sb_empty", exp_q.size(), 0);
    check("ct_hold", hold_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: request to encrypt; sampled on each clk edge.
REQ-005 Port plaintext, input, [0:127]: input block; byte 0 = bits [0:7]; column-major state per FIPS-197.
REQ-006 Port w, input, [0:1407]: expanded key from the key-expansion stage; round key r = w[128*r +: 128], r = 0..10.
REQ-007 Port busy, output, 1 bit: encryption in progress.
REQ-008 Port done, output, 1 bit: single-cycle completion pulse.
REQ-009 Port ciphertext, output, [0:127]: result; valid from done onward.

Function
REQ-010 The FSM SHALL have two states: IDLE and RUN.
REQ-011 In IDLE with start=1 at edge E0, the block SHALL load state <= plaintext ^ w[0:127], set round=1, set busy=1 and enter RUN.
REQ-012 In RUN at each edge, the block SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(w round key) for rounds 1..9, one round per edge.
REQ-013 Round 10 SHALL omit MixColumns.
REQ-014 On the round-10 edge (E10), the block SHALL load ciphertext with the round-10 result, pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-015 Latency SHALL be 10 cycles from the start-sampling edge to done high; throughput SHALL be one block per 11 edges maximum.
REQ-016 start while busy=1 SHALL be ignored, with no effect on state, round or outputs.
REQ-017 start in the cycle where done=1 SHALL be accepted (back-to-back), because busy=0 in that cycle.
REQ-018 ciphertext SHALL change only at the completion edge and SHALL otherwise hold its last value.
REQ-019 Upstream SHALL hold w stable from the start edge through the done cycle; w SHALL NOT be registered internally; plaintext SHALL be sampled only at the start edge.
REQ-020 The round counter SHALL be 4 bits, counting 1..10, and SHALL reset to 0 in IDLE; values 11..15 SHALL be unreachable.
REQ-021 GF(2^8) MixColumns SHALL use xtime with reduction polynomial 0x11B; all byte arithmetic SHALL be 8-bit modulo.

Reset
REQ-022 When rst=1 at an edge, the block SHALL go to IDLE with busy=0, done=0, ciphertext=0, internal state=0 and round=0.
REQ-023 rst SHALL take priority over start and over an in-flight operation (abort with no done pulse).
REQ-024 A start in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-025 A shared package aes_pkg SHALL hold NR=10, NB=4, BLOCK_W=128, EXPKEY_W=1408 and the IDLE/RUN state encoding.
REQ-026 A sub-module aes_sbox (8-bit combinational FIPS-197 S-box) SHALL be instantiated 16 times for SubBytes.
REQ-027 ShiftRows and MixColumns SHALL be local functions in aes_cipher_iter.

Verification
REQ-028 Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, ciphertext=0; no operation starts.
REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c expanded, pt 3243f6a8885a308d313198a2e0370734 -> done exactly 10 cycles after the start edge; ct 3925841d02dc09fbdc118597196a0b32.
REQ-030 Back-to-back: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, start asserted in the done cycle of REQ-029 -> second done 11 cycles after the first; ct 69c4e0d86a7b0430d8cdb78070b4c55a; first ct held until then.
REQ-031 Start while busy: pulse start with a different plaintext at rounds 3 and 9 -> ignored; ct per REQ-029 unchanged; exactly one done pulse.
REQ-032 Reset mid-operation: rst at round 5 -> no done, outputs 0; then start with the REQ-029 vector -> correct ct after 10 cycles.
